// File: rtl/ysyx_mc_ctrl_pkg.sv
// ysyx_ctrl_pkg: shared definitions for the NPC multi-cycle control sequencer.
// Contents:
//   state_t     - 3-bit sequencer state encoding (also exported on state_o)
//   ERR_*       - 2-bit fault cause codes reported on err_code
//   is_running  - true for states in which the cycle counter advances
package ysyx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_MEM   = 3'd3,
    ST_WB    = 3'd4,
    ST_HALT  = 3'd5,
    ST_ERR   = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE         = 2'd0;
  localparam logic [1:0] ERR_IFU_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_LSU_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_DEC_CONFLICT = 2'd3;

  // HALT and ERR are absorbing; every other state counts as an active cycle.
  function automatic logic is_running(input state_t s);
    return (s != ST_HALT) && (s != ST_ERR);
  endfunction

endpackage

// File: rtl/ysyx_mc_ctrl_if.sv
// ysyx_mc_ctrl_if: handshake bundle between the control sequencer and the
// datapath / memory ports.
//   ifu_req/ifu_ack     instruction fetch handshake, ir_wr_en captures IR
//   dec_*               decoder outputs for the current instruction register
//   lsu_req/wen/ack     data memory handshake
//   rf_wr_en, pc_wr_en  gated architectural update strobes
// Modports: master = sequencer side, slave = datapath/memory side.
interface ysyx_mc_ctrl_if;

  logic ifu_req;
  logic ifu_ack;
  logic ir_wr_en;
  logic dec_rf_wr_en;
  logic dec_is_load;
  logic dec_is_store;
  logic dec_is_ebreak;
  logic lsu_req;
  logic lsu_wen;
  logic lsu_ack;
  logic rf_wr_en;
  logic pc_wr_en;

  modport master (
    output ifu_req, ir_wr_en, lsu_req, lsu_wen, rf_wr_en, pc_wr_en,
    input  ifu_ack, lsu_ack, dec_rf_wr_en, dec_is_load, dec_is_store, dec_is_ebreak
  );

  modport slave (
    input  ifu_req, ir_wr_en, lsu_req, lsu_wen, rf_wr_en, pc_wr_en,
    output ifu_ack, lsu_ack, dec_rf_wr_en, dec_is_load, dec_is_store, dec_is_ebreak
  );

endinterface

// File: rtl/ysyx_mc_ctrl_wait_timer.sv
// ysyx_wait_timer: counts cycles spent waiting on a memory port.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clear     synchronous clear (held while no port is being waited on)
//   en        count this cycle (port waiting, no ack)
//   expired   count has reached TIMEOUT
// The count saturates at TIMEOUT so expired stays asserted once reached.
module ysyx_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  assign expired = (count == CW'(TIMEOUT));

  // Wait-cycle counter, saturating at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/ysyx_mc_ctrl.sv
// ysyx_mc_ctrl: multi-cycle control sequencer for the NPC core.
// Steps each instruction through FETCH -> EXEC -> (MEM) -> WB and gates the
// register-file write and PC update so each fires once per instruction.
// Ports:
//   clk, rst             core clock, asynchronous active-high reset
//   bus (master)         fetch / decode / LSU handshake bundle
//   halt, err            sticky status (ebreak reached, fault reached)
//   err_code             fault cause, written on entry to ERR
//   state_o              current state for debug
//   mcycle, minstret     64-bit cycle and retired-instruction counters
module ysyx_mc_ctrl
  import ysyx_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  ysyx_mc_ctrl_if.master        bus,
  output logic                  halt,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [2:0]            state_o,
  output logic [63:0]           mcycle,
  output logic [63:0]           minstret
);

  state_t state;
  logic   in_fetch;
  logic   in_mem;
  logic   in_wb;
  logic   wait_clear;
  logic   wait_en;
  logic   wait_expired;

  assign in_fetch = (state == ST_FETCH);
  assign in_mem   = (state == ST_MEM);
  assign in_wb    = (state == ST_WB);

  // FETCH never leads straight to MEM, so holding the timer clear outside the
  // two wait states guarantees it starts from zero on every entry.
  assign wait_clear = !(in_fetch || in_mem);
  assign wait_en    = (in_fetch && !bus.ifu_ack) || (in_mem && !bus.lsu_ack);

  ysyx_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .en      (wait_en),
    .expired (wait_expired)
  );

  // Requests are pure decodes of the state register, so they are glitch-free
  // and fall together with an asynchronous reset.
  assign bus.ifu_req  = in_fetch;
  assign bus.ir_wr_en = in_fetch & bus.ifu_ack;
  assign bus.lsu_req  = in_mem;
  assign bus.lsu_wen  = in_mem & bus.dec_is_store;
  assign bus.rf_wr_en = in_wb & bus.dec_rf_wr_en;
  assign bus.pc_wr_en = in_wb;
  assign state_o      = state;

  // Sequencer state, sticky status and performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      halt     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      if (is_running(state)) begin
        mcycle <= mcycle + 64'd1;
      end else begin
        mcycle <= mcycle;
      end

      case (state)
        ST_IDLE: begin
          state <= ST_FETCH;
        end

        // An ack arriving in the same cycle the timer expires wins.
        ST_FETCH: begin
          if (bus.ifu_ack) begin
            state <= ST_EXEC;
          end else if (wait_expired) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_IFU_TIMEOUT;
          end else begin
            state <= ST_FETCH;
          end
        end

        ST_EXEC: begin
          if (bus.dec_is_load && bus.dec_is_store) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_DEC_CONFLICT;
          end else if (bus.dec_is_ebreak) begin
            state    <= ST_HALT;
            halt     <= 1'b1;
            minstret <= minstret + 64'd1;
          end else if (bus.dec_is_load || bus.dec_is_store) begin
            state <= ST_MEM;
          end else begin
            state <= ST_WB;
          end
        end

        ST_MEM: begin
          if (bus.lsu_ack) begin
            state <= ST_WB;
          end else if (wait_expired) begin
            state    <= ST_ERR;
            err      <= 1'b1;
            err_code <= ERR_LSU_TIMEOUT;
          end else begin
            state <= ST_MEM;
          end
        end

        ST_WB: begin
          state    <= ST_FETCH;
          minstret <= minstret + 64'd1;
        end

        ST_HALT: begin
          state <= ST_HALT;
        end

        ST_ERR: begin
          state <= ST_ERR;
        end

        // Unreachable encoding: park in the fault state, keep the cause.
        default: begin
          state <= ST_ERR;
          err   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_mc_ctrl.sv
// tb_ysyx_mc_ctrl: self-checking bench for ysyx_mc_ctrl.
// Main instance uses the default TIMEOUT; a second instance with TIMEOUT=4
// exercises the fetch/LSU timeout paths. Instruction latency and counter
// values are predicted from the per-instruction cycle budget
// (fetch wait + ack, exec, optional memory wait + ack, writeback).
module tb_ysyx_mc_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst4;

  ysyx_mc_ctrl_if bus();
  ysyx_mc_ctrl_if bus4();

  logic        halt, err, halt4, err4;
  logic [1:0]  err_code, err_code4;
  logic [2:0]  state_o, state_o4;
  logic [63:0] mcycle, minstret, mcycle4, minstret4;

  ysyx_mc_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus),
    .halt(halt), .err(err), .err_code(err_code), .state_o(state_o),
    .mcycle(mcycle), .minstret(minstret)
  );

  ysyx_mc_ctrl #(.TIMEOUT(4)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4),
    .halt(halt4), .err(err4), .err_code(err_code4), .state_o(state_o4),
    .mcycle(mcycle4), .minstret(minstret4)
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_mcycle;
  logic [63:0] exp_minstret;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_main_inputs();
    bus.ifu_ack = 1'b0; bus.lsu_ack = 1'b0; bus.dec_rf_wr_en = 1'b0;
    bus.dec_is_load = 1'b0; bus.dec_is_store = 1'b0; bus.dec_is_ebreak = 1'b0;
  endtask

  // Cycles an instruction should take: kind 0 = ALU, 1 = load, 2 = store.
  function automatic int latency(input int kind, input int fd, input int md);
    return (fd + 1) + 1 + ((kind != 0) ? (md + 1) : 0) + 1;
  endfunction

  // Reset the main instance and leave it in its first FETCH cycle (#1 after edge).
  task automatic rst_main();
    rst = 1'b1;
    clear_main_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("fetch_after_rst", bus.ifu_req, 64'd1);
    exp_mcycle   = 64'd1;
    exp_minstret = 64'd0;
  endtask

  // Run one instruction on the main instance, starting in FETCH (#1 after edge).
  // The memory side acks after fd / md wait cycles.
  task automatic run_instr(input int kind, input int fd, input int md, input logic rfw);
    int fw, mw, ncyc, irc, rfc, pcc, lreq, wenc;
    bit done;
    fw = 0; mw = 0; ncyc = 0; irc = 0; rfc = 0; pcc = 0; lreq = 0; wenc = 0; done = 1'b0;
    bus.dec_is_load   = (kind == 1);
    bus.dec_is_store  = (kind == 2);
    bus.dec_is_ebreak = 1'b0;
    bus.dec_rf_wr_en  = rfw;
    while (!done && ncyc < 64) begin
      bus.ifu_ack = bus.ifu_req && (fw == fd);
      bus.lsu_ack = bus.lsu_req && (mw == md);
      @(negedge clk);
      irc += int'(bus.ir_wr_en);
      rfc += int'(bus.rf_wr_en);
      pcc += int'(bus.pc_wr_en);
      if (bus.ifu_req) fw++;
      if (bus.lsu_req) begin
        mw++;
        lreq++;
        wenc += int'(bus.lsu_wen);
      end
      ncyc++;
      if (bus.pc_wr_en) done = 1'b1;
      @(posedge clk); #1;
    end
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    exp_mcycle   = exp_mcycle + 64'(latency(kind, fd, md));
    exp_minstret = exp_minstret + 64'd1;
    chk("instr_cycles", 64'(ncyc), 64'(latency(kind, fd, md)));
    chk("fetch_req_cycles", 64'(fw), 64'(fd + 1));
    chk("ir_wr_pulses", 64'(irc), 64'd1);
    chk("pc_wr_pulses", 64'(pcc), 64'd1);
    chk("rf_wr_pulses", 64'(rfc), 64'(rfw));
    chk("lsu_req_cycles", 64'(lreq), (kind != 0) ? 64'(md + 1) : 64'd0);
    chk("lsu_wen_cycles", 64'(wenc), (kind == 2) ? 64'(md + 1) : 64'd0);
    chk("mcycle", mcycle, exp_mcycle);
    chk("minstret", minstret, exp_minstret);
    chk("next_fetch", bus.ifu_req, 64'd1);
  endtask

  initial begin
    int cnt;
    rst  = 1'b1;
    rst4 = 1'b1;
    clear_main_inputs();
    bus4.ifu_ack = 1'b0; bus4.lsu_ack = 1'b0; bus4.dec_rf_wr_en = 1'b0;
    bus4.dec_is_load = 1'b0; bus4.dec_is_store = 1'b0; bus4.dec_is_ebreak = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ifu_req", bus.ifu_req, 64'd0);
    chk("rst_lsu_req", bus.lsu_req, 64'd0);
    chk("rst_pc_wr", bus.pc_wr_en, 64'd0);
    chk("rst_halt", halt, 64'd0);
    chk("rst_err", err, 64'd0);
    chk("rst_err_code", err_code, 64'd0);
    chk("rst_state", state_o, 64'd0);
    chk("rst_mcycle", mcycle, 64'd0);
    chk("rst_minstret", minstret, 64'd0);

    // Release after edge 1; ifu_req must appear only after edge 2.
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", bus.ifu_req, 64'd0);
    chk("idle_state", state_o, 64'd0);
    @(posedge clk); #1;
    chk("edge2_req", bus.ifu_req, 64'd1);
    exp_mcycle   = 64'd1;
    exp_minstret = 64'd0;

    // Directed: ALU, load with 5-cycle ack delay, store without rf write.
    run_instr(0, 0, 0, 1'b1);
    run_instr(1, 0, 5, 1'b1);
    run_instr(2, 0, 0, 1'b0);

    // Random instruction mix with random ack delays.
    for (int i = 0; i < 25; i++) begin
      run_instr(int'($urandom_range(0, 2)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 6)), logic'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a load.
    bus.dec_is_load = 1'b1;
    bus.ifu_ack = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ack = 1'b0;
    @(posedge clk); #1;
    chk("mem_req_before_rst", bus.lsu_req, 64'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("mid_mem_rst_lsu_req", bus.lsu_req, 64'd0);
    chk("mid_mem_rst_state", state_o, 64'd0);
    chk("mid_mem_rst_mcycle", mcycle, 64'd0);
    chk("mid_mem_rst_minstret", minstret, 64'd0);

    // Load+store decode conflict.
    rst_main();
    bus.dec_is_load = 1'b1;
    bus.dec_is_store = 1'b1;
    bus.ifu_ack = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ack = 1'b0;
    @(posedge clk); #1;
    chk("conflict_err", err, 64'd1);
    chk("conflict_code", err_code, 64'd3);
    chk("conflict_state", state_o, 64'd6);
    chk("conflict_halt", halt, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("conflict_mcycle_frozen", mcycle, 64'd3);
    chk("conflict_no_req", bus.ifu_req, 64'd0);
    chk("conflict_minstret", minstret, 64'd0);

    // Three ADDs then ebreak.
    rst_main();
    run_instr(0, 0, 0, 1'b1);
    run_instr(0, 1, 0, 1'b1);
    run_instr(0, 2, 0, 1'b1);
    bus.dec_is_ebreak = 1'b1;
    bus.dec_is_load = 1'b0;
    bus.dec_is_store = 1'b0;
    bus.ifu_ack = 1'b1;
    @(posedge clk); #1;
    bus.ifu_ack = 1'b0;
    @(posedge clk); #1;
    exp_mcycle = exp_mcycle + 64'd2;
    chk("ebreak_halt", halt, 64'd1);
    chk("ebreak_err", err, 64'd0);
    chk("ebreak_state", state_o, 64'd5);
    chk("ebreak_minstret", minstret, 64'd4);
    bus.ifu_ack = 1'b1;
    bus.lsu_ack = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cnt += int'(bus.ifu_req) + int'(bus.ir_wr_en) + int'(bus.rf_wr_en) + int'(bus.pc_wr_en);
    end
    bus.ifu_ack = 1'b0;
    bus.lsu_ack = 1'b0;
    chk("halt_stray_ack_no_activity", 64'(cnt), 64'd0);
    chk("halt_mcycle_frozen", mcycle, exp_mcycle);
    chk("halt_minstret_held", minstret, 64'd4);
    chk("halt_state_held", state_o, 64'd5);

    // TIMEOUT=4: fetch ack never arrives.
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt += int'(bus4.ifu_req);
      @(posedge clk); #1;
    end
    chk("ifu_to_req_cycles", 64'(cnt), 64'd5);
    chk("ifu_to_err", err4, 64'd1);
    chk("ifu_to_code", err_code4, 64'd1);
    chk("ifu_to_state", state_o4, 64'd6);
    chk("ifu_to_mcycle_frozen", mcycle4, 64'd6);

    // TIMEOUT=4: ack arrives exactly as the counter reaches TIMEOUT.
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    @(posedge clk); #1;
    bus4.dec_rf_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus4.ifu_ack = (i == 4);
      @(posedge clk); #1;
    end
    bus4.ifu_ack = 1'b0;
    chk("ack_at_to_exec", state_o4, 64'd2);
    @(posedge clk); #1;
    chk("ack_at_to_pc_wr", bus4.pc_wr_en, 64'd1);
    chk("ack_at_to_rf_wr", bus4.rf_wr_en, 64'd1);
    @(posedge clk); #1;
    chk("ack_at_to_no_err", err4, 64'd0);
    chk("ack_at_to_minstret", minstret4, 64'd1);
    chk("ack_at_to_mcycle", mcycle4, 64'd8);
    chk("ack_at_to_refetch", bus4.ifu_req, 64'd1);

    // TIMEOUT=4: LSU ack never arrives.
    bus4.dec_is_load = 1'b1;
    bus4.ifu_ack = 1'b1;
    @(posedge clk); #1;
    bus4.ifu_ack = 1'b0;
    @(posedge clk); #1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cnt += int'(bus4.lsu_req);
      @(posedge clk); #1;
    end
    chk("lsu_to_req_cycles", 64'(cnt), 64'd5);
    chk("lsu_to_err", err4, 64'd1);
    chk("lsu_to_code", err_code4, 64'd2);
    chk("lsu_to_state", state_o4, 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_mc_ctrl.md
# ysyx_mc_ctrl

Multi-cycle control sequencer for the NPC core. It steps each instruction through fetch, execute, memory and writeback, and handshakes with the instruction-fetch and load/store memory ports. It gates the combinational decoder's register-file write enable and the PC update so each happens exactly once per instruction. It also maintains the cycle and retired-instruction counters and the halt/error status used by the simulation environment.

## Interface
Parameters:
- TIMEOUT, 255: maximum number of wait cycles on either memory port before the controller enters ERR.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- ifu_req  out  1  instruction fetch request.
- ifu_ack  in  1  fetch data valid this cycle.
- ir_wr_en  out  1  datapath captures the instruction register this cycle.
- dec_rf_wr_en  in  1  register-file write enable from the decoder, for the current instruction register.
- dec_is_load  in  1  decoded instruction is a load.
- dec_is_store  in  1  decoded instruction is a store.
- dec_is_ebreak  in  1  decoded instruction is ebreak.
- lsu_req  out  1  data memory request.
- lsu_wen  out  1  data request is a write.
- lsu_ack  in  1  data access complete; load data is valid this cycle.
- rf_wr_en  out  1  gated register-file write enable.
- pc_wr_en  out  1  PC register loads the next PC.
- halt  out  1  ebreak reached; sticky.
- err  out  1  fault state reached; sticky.
- err_code  out  2  fault cause: 0 none, 1 fetch timeout, 2 LSU timeout, 3 load+store decode conflict.
- state_o  out  3  current state, for debug.
- mcycle  out  64  cycle counter.
- minstret  out  64  retired-instruction counter.

## Operation
States: IDLE, FETCH, EXEC, MEM, WB, HALT, ERR.
- **IDLE** (reset state): unconditionally goes to FETCH on the next clock.
- **FETCH**
  - ifu_req=1, held until ifu_ack.
  - ir_wr_en = ifu_ack, combinational, asserted only in FETCH.
  - On ack, go to EXEC.
- **EXEC** (decoder outputs are valid), in priority order:
  - dec_is_load & dec_is_store → ERR, code 3.
  - dec_is_ebreak → HALT; minstret increments.
  - dec_is_load | dec_is_store → MEM.
  - otherwise → WB.
- **MEM**
  - lsu_req=1 and lsu_wen=dec_is_store, both held until lsu_ack.
  - On ack, go to WB.
- **WB** (one cycle): rf_wr_en=dec_rf_wr_en, pc_wr_en=1, minstret+1, then FETCH.
- **HALT / ERR**: absorbing states; only rst exits them. halt=1 in HALT; err=1 in ERR.
- **Timeout counter**
  - Cleared on entry to FETCH and to MEM; increments each cycle the port waits.
  - At TIMEOUT with no ack: ERR, code 1 from FETCH or 2 from MEM.
  - An ack in the same cycle the counter reaches TIMEOUT wins; no error is raised.
- **Stray acks**: ifu_ack outside FETCH and lsu_ack outside MEM are ignored.
- **Counters**
  - mcycle increments every cycle in states IDLE..WB and freezes in HALT and ERR.
  - Both counters are 64-bit and wrap modulo 2^64.
- err_code is written on entry to ERR and is otherwise held.

## Timing
- Reset: state=IDLE, all outputs 0, counters 0, err_code 0. Applied asynchronously, including mid-instruction; any pending req drops immediately.
- ifu_req and lsu_req are registered-state decodes: glitch-free and stable while waiting.
- ir_wr_en, rf_wr_en and pc_wr_en are pulses lasting exactly one cycle per instruction.
- Minimum instruction latency with ack in the same cycle as req:
  - ALU or jump: 3 cycles (FETCH, EXEC, WB).
  - Load or store: 4 cycles.
- Each cycle of ack delay adds one cycle.
- From rst deassertion, the first ifu_req is asserted on the second rising edge (IDLE → FETCH).

## Structure
- Shared package ysyx_ctrl_pkg holds:
  - the 3-bit state encoding (IDLE=0, FETCH=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6);
  - the 2-bit err_code constants.
- Sub-module ysyx_wait_timer: the TIMEOUT counter, with clear, enable and expired outputs.
- Everything else lives in one FSM module.

## Test plan
- **ALU path**: rst, then ADD with ifu_ack immediate and dec_rf_wr_en=1 → ifu_req at edge 2; rf_wr_en and pc_wr_en each pulse once, 3 cycles after fetch start; minstret=1.
- **Load with wait**: dec_is_load, lsu_ack delayed 5 cycles → lsu_req=1 and lsu_wen=0 for 6 cycles; WB follows the ack; instruction takes 9 cycles total.
- **Store**: dec_is_store, dec_rf_wr_en=0 → lsu_wen=1 in MEM; rf_wr_en stays 0; pc_wr_en pulses once.
- **Timeouts**, with TIMEOUT=4:
  - ifu_ack never arrives → ERR with err_code=1; mcycle frozen.
  - ack exactly at the TIMEOUT cycle → normal completion, err=0.
- **ebreak**: after 3 retired ADDs → halt=1, minstret=4; no further ifu_req; a stray ifu_ack has no effect.
- **Reset and conflict**: rst asserted mid-MEM → lsu_req falls in the same cycle; counters reach 0. A load+store decode conflict → ERR with err_code=3.
